// File: rtl/serializer_pkg.sv
// Shared types and helpers for the word serializer.
package serializer_pkg;

    // Frame sequencer states, in the order a frame passes through them.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    // Number of clock cycles one complete frame occupies on the line.
    function automatic int frame_len(input int width, input int parity, input int clks_per_bit);
        return (2 + width + parity) * clks_per_bit;
    endfunction

endpackage

// File: rtl/word_fifo.sv
// Circular word buffer with registered ready and an occupancy count that
// tells full apart from empty when the pointers coincide.
module word_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ready_q, ready_d;
    logic             push;
    logic             pop;

    // Accept/pop qualification, pointer advance and occupancy bookkeeping.
    always_comb begin
        push     = wr_valid && ready_q;
        pop      = rd_en && (level_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push && pop) begin
            level_d = level_q - 1'b1;
        end
        // Ready tracks the post-update occupancy so a full buffer can never
        // be written, even when a pop frees a slot in the same cycle.
        ready_d = (level_d != LVL_FULL);
    end

    // Control state; everything clears when reset is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ready_q  <= ready_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data  = mem[rd_ptr_q];
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign wr_ready = ready_q;

endmodule

// File: rtl/word_serializer.sv
// Buffers parallel words and sends each as a start/data/parity/stop frame
// on a single idle-high line, LSB first.
module word_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH        = 9,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY       = 1,
    parameter int DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     tx,
    output logic                     busy,
    output logic                     frame_done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic             baud_end;
    logic             pop;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;

    word_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (in_data),
        .wr_valid (in_valid),
        .wr_ready (in_ready),
        .rd_en    (pop),
        .rd_data  (fifo_data),
        .empty    (fifo_empty),
        .level    (level)
    );

    // Next-state logic: baud timing, bit stepping, word fetch, and the line
    // value / done strobe for the upcoming cycle so both outputs are flops.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        pop      = 1'b0;
        baud_end = (baud_q == BAUD_LAST);
        baud_d   = baud_end ? '0 : baud_q + 1'b1;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!fifo_empty) begin
                    pop      = 1'b1;
                    shift_d  = fifo_data;
                    parity_d = ^fifo_data;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (baud_end) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        shift_d = shift_q >> 1;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (baud_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (baud_end) begin
                    // Fetch the next word straight into a start bit so
                    // consecutive frames run with no idle gap.
                    if (!fifo_empty) begin
                        pop      = 1'b1;
                        shift_d  = fifo_data;
                        parity_d = ^fifo_data;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PAR:     tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
        done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
    end

    // Sequencer registers; reset parks the line high and abandons any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
        end
    end

    assign tx         = tx_q;
    assign frame_done = done_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: a sampler records every accepted word into a
// scoreboard queue, a monitor decodes each frame from tx and checks it.
module tb_word_serializer;
    import serializer_pkg::*;

    localparam int W  = 9;
    localparam int C  = 4;
    localparam int F  = 48;   // (2 + 9 + 1) * 4
    localparam int NB = 12;   // start + 9 data + parity + stop

    logic       clk;
    logic       rst;
    logic [8:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic [2:0] level;

    logic [7:0] in_data_b;
    logic       in_valid_b;
    logic       in_ready_b;
    logic       tx_b;
    logic       busy_b;
    logic       frame_done_b;
    logic [2:0] level_b;

    int         compared;
    int         mismatched;
    logic [8:0] exp_q[$];
    time        start_times[$];
    logic [NB-1:0] last_bits;

    word_serializer #(.WIDTH(W), .CLKS_PER_BIT(C), .PARITY(1), .DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx(tx), .busy(busy), .frame_done(frame_done),
        .level(level)
    );

    word_serializer #(.WIDTH(8), .CLKS_PER_BIT(C), .PARITY(0), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .tx(tx_b), .busy(busy_b), .frame_done(frame_done_b),
        .level(level_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Scoreboard feed: a word is accepted at the coming edge when valid and ready.
    initial forever begin
        @(negedge clk);
        #1;
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(in_data);
        end
    end

    // Frame monitor: capture F cycles from the first low tx, decode, compare.
    initial forever begin : monitor
        logic [F-1:0]  s;
        logic [F-1:0]  fd;
        logic [F-1:0]  bz;
        logic [NB-1:0] bits;
        logic [8:0]    e;
        logic          ok_shape;
        logic          aborted;
        @(negedge clk);
        if (!rst && tx === 1'b0) begin
            start_times.push_back($time);
            s[0] = tx; fd[0] = frame_done; bz[0] = busy;
            aborted = 1'b0;
            for (int k = 1; k < F; k++) begin
                @(negedge clk);
                if (rst) begin
                    aborted = 1'b1;
                    break;
                end
                s[k] = tx; fd[k] = frame_done; bz[k] = busy;
            end
            if (!aborted) begin
                ok_shape = 1'b1;
                for (int b = 0; b < NB; b++) begin
                    bits[b] = s[C*b+1];
                    for (int j = 0; j < C; j++) begin
                        if (s[C*b+j] !== bits[b]) ok_shape = 1'b0;
                    end
                end
                if (bits[0] !== 1'b0 || bits[NB-1] !== 1'b1 || bz !== {F{1'b1}}) ok_shape = 1'b0;
                last_bits = bits;
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_frame: actual %0h required none", bits[9:1]);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_word", 64'(bits[9:1]), 64'(e));
                    check("frame_parity", 64'(bits[10]), 64'(^e));
                end
                check("frame_shape", 64'(ok_shape), 64'd1);
                check("frame_done_pos", 64'(fd), 64'({1'b1, {(F-1){1'b0}}}));
            end
        end
    end

    // Wait for in_ready (bounded), present one word for one cycle.
    task automatic push_word(input logic [8:0] w);
        int k;
        k = 0;
        while (!in_ready && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) begin
            compared++;
            mismatched++;
            $display("FAIL push_timeout: actual ready 0 required 1");
        end
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 20000) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(k < 20000), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!frame_done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin : stim
        int cyc;
        int low;
        int hi;
        logic [NB-1:0] seq;
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_valid_b = 1'b0;
        in_data_b  = '0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx", 64'(tx), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_tx_b", 64'(tx_b), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(in_ready), 64'd1);

        // Single word 9'h1A5: latency, bit sequence, frame_done at cycle 48
        push_word(9'h1A5);
        check("lat_tx_before_pop", 64'(tx), 64'd1);
        check("lat_level_1", 64'(level), 64'd1);
        @(negedge clk);
        check("lat_tx_start", 64'(tx), 64'd0);
        check("lat_busy", 64'(busy), 64'd1);
        check("lat_level_0", 64'(level), 64'd0);
        wait_done(cyc);
        check("single_done_cycle", 64'(cyc + 1), 64'(F));
        repeat (2) @(negedge clk);
        seq = 12'b1_1_110100101_0;  // stop, parity, data 1A5, start (LSB sent first)
        check("single_bits", 64'(last_bits), 64'(seq));
        check("single_busy_end", 64'(busy), 64'd0);

        // 8-bit, no-parity instance: 36 low cycles, 40-cycle frame
        check("b_ready", 64'(in_ready_b), 64'd1);
        in_valid_b = 1'b1;
        in_data_b  = 8'h00;
        @(negedge clk);
        in_valid_b = 1'b0;
        @(negedge clk);
        low = 0;
        while (tx_b == 1'b0 && low < 100) begin
            low++;
            @(negedge clk);
        end
        check("b_low_cycles", 64'(low), 64'd36);
        hi = 1;
        while (!frame_done_b && hi < 100) begin
            @(negedge clk);
            hi++;
        end
        check("b_frame_len", 64'(low + hi), 64'(frame_len(8, 0, C)));
        check("b_stop_high", 64'(tx_b), 64'd1);
        repeat (2) @(negedge clk);

        // Fill: 5 consecutive words, then a held push against a full FIFO
        start_times.delete();
        push_word(9'h101);
        push_word(9'h0F0);
        push_word(9'h03C);
        push_word(9'h1FF);
        push_word(9'h002);
        check("fill_level_max", 64'(level), 64'd4);
        check("fill_ready_low", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_data  = 9'h0AA;
        @(negedge clk);
        check("full_refused_level", 64'(level), 64'd4);
        wait_done(cyc);
        check("full_pop_ready_low", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("full_after_pop_level", 64'(level), 64'd3);
        check("full_ready_returns", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("full_refill_level", 64'(level), 64'd4);
        drain("fill_drain");
        check("fill_frames", 64'(start_times.size()), 64'd6);
        for (int i = 1; i < start_times.size(); i++) begin
            check("b2b_gap", 64'(start_times[i] - start_times[i-1]), 64'(F * 10));
        end

        // Simultaneous push and pop at level 2
        push_word(9'h011);
        push_word(9'h022);
        push_word(9'h033);
        check("pp_level_before", 64'(level), 64'd2);
        wait_done(cyc);
        in_valid = 1'b1;
        in_data  = 9'h155;
        @(negedge clk);
        in_valid = 1'b0;
        check("pp_level_same", 64'(level), 64'd2);
        drain("pp_drain");

        // Reset in the middle of a data bit
        push_word(9'h0C3);
        push_word(9'h13C);
        push_word(9'h077);
        repeat (12) @(negedge clk);
        check("mid_busy_pre", 64'(busy), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_tx", 64'(tx), 64'd1);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_level", 64'(level), 64'd0);
        check("mid_rst_ready", 64'(in_ready), 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_ready_after", 64'(in_ready), 64'd1);
        low = 0;
        for (int i = 0; i < 60; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) low++;
            @(negedge clk);
        end
        check("mid_no_residual", 64'(low), 64'd0);

        // Random words with random idle gaps
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 6)) @(negedge clk);
            push_word(9'($urandom_range(0, 511)));
        end
        drain("rand_drain");
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
